// File: rtl/gshare_predictor_param.sv
// Parametrised gshare/bimodal branch direction predictor with a tracked
// prediction pipe, in-place counter training and sequential table init.
module gshare_predictor_param #(
    parameter int PC_W       = 32,
    parameter int IDX_W      = 5,
    parameter int HIST_W     = 5,
    parameter int CTR_W      = 2,
    parameter int CTR_INIT   = 1,
    parameter int PIPE_DEPTH = 2,
    parameter int MODE       = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] current_pc,
    input  logic            stall,
    input  logic            flush,
    input  logic            update,
    input  logic            real_taken,
    output logic            taken,
    output logic            ready,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);
    localparam logic [CTR_W-1:0] CTR_MAX    = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             r_state, w_state_next;
    logic [IDX_W-1:0]   r_init_ptr, w_init_ptr_next;
    logic [HIST_W-1:0]  r_history, w_hist_next;
    logic [CTR_W-1:0]   r_table [DEPTH];
    logic [31:0]        r_branch_cnt, r_mispred_cnt;

    logic               r_stg_valid [PIPE_DEPTH];
    logic [IDX_W-1:0]   r_stg_idx   [PIPE_DEPTH];
    logic               r_stg_pred  [PIPE_DEPTH];

    logic [IDX_W-1:0]   w_pc_idx, w_hist_ext, w_idx, w_last_idx;
    logic [CTR_W-1:0]   w_ctr_rd, w_ctr_tr, w_ctr_new;
    logic               w_last_valid, w_last_pred, w_train, w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_ptr <= w_init_ptr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_ptr_next = r_init_ptr;
        case (r_state)
            S_INIT: begin
                w_init_ptr_next = r_init_ptr + 1'b1;
                if (r_init_ptr == '1)
                    w_state_next = S_RUN;
            end
            default: ;
        endcase
    end

    assign ready      = (r_state == S_RUN);
    assign w_pc_idx   = current_pc[IDX_W+1:2];
    assign w_hist_ext = IDX_W'(r_history);
    // Only the index bits of the PC (and history in bimodal mode) feed the logic.
    assign w_unused   = ^{current_pc, r_history};

    generate
        if (MODE == 1) begin : g_gshare
            assign w_idx = w_pc_idx ^ w_hist_ext;
        end else begin : g_bimodal
            assign w_idx = w_pc_idx;
        end
        if (HIST_W == 1) begin : g_hist1
            assign w_hist_next = real_taken;
        end else begin : g_histn
            assign w_hist_next = {r_history[HIST_W-2:0], real_taken};
        end
    endgenerate

    // Prediction reads the stored value; a same-cycle training write is not bypassed.
    assign w_ctr_rd = r_table[w_idx];
    assign taken    = ready & w_ctr_rd[CTR_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (reset || flush)
                        r_stg_valid[gi] <= 1'b0;
                    else if (!stall)
                        r_stg_valid[gi] <= ready;
                    if (!stall) begin
                        r_stg_idx[gi]  <= w_idx;
                        r_stg_pred[gi] <= taken;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (reset || flush)
                        r_stg_valid[gi] <= 1'b0;
                    else if (!stall)
                        r_stg_valid[gi] <= r_stg_valid[gi-1];
                    if (!stall) begin
                        r_stg_idx[gi]  <= r_stg_idx[gi-1];
                        r_stg_pred[gi] <= r_stg_pred[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign w_last_valid = r_stg_valid[PIPE_DEPTH-1];
    assign w_last_idx   = r_stg_idx[PIPE_DEPTH-1];
    assign w_last_pred  = r_stg_pred[PIPE_DEPTH-1];
    assign w_train      = (r_state == S_RUN) && update && w_last_valid && !reset;
    assign w_ctr_tr     = r_table[w_last_idx];

    always_comb begin
        w_ctr_new = w_ctr_tr;
        if (real_taken) begin
            if (w_ctr_tr != CTR_MAX)
                w_ctr_new = w_ctr_tr + 1'b1;
        end else begin
            if (w_ctr_tr != '0)
                w_ctr_new = w_ctr_tr - 1'b1;
        end
    end

    // Table contents survive reset; INIT rewrites every entry afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_INIT)
                r_table[r_init_ptr] <= CTR_INIT_V;
            else if (w_train)
                r_table[w_last_idx] <= w_ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_history     <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_train) begin
            r_history    <= w_hist_next;
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_last_pred != real_taken)
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_gshare_predictor_param.sv
// Bench for gshare_predictor_param: a bimodal and a gshare instance share
// stimulus; a behavioural model feeds an expectation queue checked every cycle.
module tb_gshare_predictor_param;
    localparam logic [31:0] FILL = 32'h100;

    logic        clk = 1'b0;
    logic        reset, stall, flush, update, real_taken;
    logic [31:0] current_pc;
    logic        taken_b, ready_b, taken_g, ready_g;
    logic [31:0] bcnt_b, mcnt_b, bcnt_g, mcnt_g;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gshare_predictor_param #(.PC_W(32), .IDX_W(5), .HIST_W(5), .CTR_W(2),
        .CTR_INIT(1), .PIPE_DEPTH(2), .MODE(0)) u_bim (
        .clk(clk), .reset(reset), .current_pc(current_pc), .stall(stall),
        .flush(flush), .update(update), .real_taken(real_taken),
        .taken(taken_b), .ready(ready_b), .branch_cnt(bcnt_b), .mispred_cnt(mcnt_b));

    gshare_predictor_param #(.PC_W(32), .IDX_W(5), .HIST_W(5), .CTR_W(2),
        .CTR_INIT(1), .PIPE_DEPTH(2), .MODE(1)) u_gsh (
        .clk(clk), .reset(reset), .current_pc(current_pc), .stall(stall),
        .flush(flush), .update(update), .real_taken(real_taken),
        .taken(taken_g), .ready(ready_g), .branch_cnt(bcnt_g), .mispred_cnt(mcnt_g));

    // Model state, index 0 = bimodal, 1 = gshare
    bit [1:0]  mt   [2][32];
    bit        mrun [2];
    int        mptr [2];
    bit [4:0]  mhist[2];
    bit        mv   [2][2];
    bit [4:0]  midx [2][2];
    bit        mp   [2][2];
    bit [31:0] mbc  [2];
    bit [31:0] mmc  [2];

    typedef struct packed {
        logic [1:0]  tk;
        logic [1:0]  rdy;
        logic [31:0] bc0, bc1, mc0, mc1;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic bit [4:0] m_idx(input int m, input logic [31:0] pc);
        return (m == 1) ? (pc[6:2] ^ mhist[m]) : pc[6:2];
    endfunction

    task automatic model_edge(input bit rst, input logic [31:0] pc, input bit st,
                              input bit fl, input bit up, input bit rt);
        for (int m = 0; m < 2; m++) begin
            bit [4:0] idx, e;
            bit       pred, rdy;
            idx  = m_idx(m, pc);
            rdy  = mrun[m];
            pred = rdy ? mt[m][idx][1] : 1'b0;
            if (rst) begin
                mrun[m] = 0; mptr[m] = 0; mhist[m] = '0;
                mv[m][0] = 0; mv[m][1] = 0; mbc[m] = '0; mmc[m] = '0;
            end else begin
                if (!mrun[m]) begin
                    mt[m][mptr[m]] = 2'd1;
                    if (mptr[m] == 31) mrun[m] = 1;
                    mptr[m] = (mptr[m] + 1) % 32;
                end else if (up && mv[m][1]) begin
                    e = midx[m][1];
                    if (rt) mt[m][e] = (mt[m][e] == 2'd3) ? 2'd3 : mt[m][e] + 2'd1;
                    else    mt[m][e] = (mt[m][e] == 2'd0) ? 2'd0 : mt[m][e] - 2'd1;
                    mhist[m] = {mhist[m][3:0], rt};
                    mbc[m]++;
                    if (mp[m][1] != rt) mmc[m]++;
                end
                if (fl) begin
                    mv[m][0] = 0; mv[m][1] = 0;
                end else if (!st) begin
                    mv[m][1] = mv[m][0]; midx[m][1] = midx[m][0]; mp[m][1] = mp[m][0];
                    mv[m][0] = rdy;      midx[m][0] = idx;        mp[m][0] = pred;
                end
            end
        end
    endtask

    // One clock: drive, queue expectation, compare at negedge, advance model at posedge.
    task automatic cyc(input bit rst, input logic [31:0] pc, input bit st,
                       input bit fl, input bit up, input bit rt);
        exp_t e;
        reset = rst; current_pc = pc; stall = st; flush = fl; update = up; real_taken = rt;
        e.tk[0] = mrun[0] ? mt[0][m_idx(0, pc)][1] : 1'b0;
        e.tk[1] = mrun[1] ? mt[1][m_idx(1, pc)][1] : 1'b0;
        e.rdy   = {mrun[1], mrun[0]};
        e.bc0 = mbc[0]; e.bc1 = mbc[1]; e.mc0 = mmc[0]; e.mc1 = mmc[1];
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check("taken_b",   {31'd0, taken_b}, {31'd0, e.tk[0]});
        check("taken_g",   {31'd0, taken_g}, {31'd0, e.tk[1]});
        check("ready_b",   {31'd0, ready_b}, {31'd0, e.rdy[0]});
        check("ready_g",   {31'd0, ready_g}, {31'd0, e.rdy[1]});
        check("branch_b",  bcnt_b, e.bc0);
        check("branch_g",  bcnt_g, e.bc1);
        check("mispred_b", mcnt_b, e.mc0);
        check("mispred_g", mcnt_g, e.mc1);
        @(posedge clk);
        model_edge(rst, pc, st, fl, up, rt);
        #1;
    endtask

    // Branch at pc, then two filler fetches; it resolves on the third cycle.
    task automatic round(input logic [31:0] pc, input bit rt);
        cyc(0, pc,   0, 0, 0, 0);
        cyc(0, FILL, 0, 0, 0, 0);
        cyc(0, FILL, 0, 0, 1, rt);
    endtask

    task automatic reset_and_init();
        cyc(1, FILL, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, {$urandom_range(0, 255), 2'b00}, 0, 0, 0, 0);
            check("init_ready_b", {31'd0, ready_b}, {31'd0, i == 31});
            if (i < 31) check("init_taken_g", {31'd0, taken_g}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; current_pc = FILL; stall = 0; flush = 0; update = 0; real_taken = 0;
        repeat (2) @(posedge clk);
        model_edge(1, FILL, 0, 0, 0, 0);
        #1;

        reset_and_init();

        // Bimodal PC 0x40 -> entry 16 trained taken three times
        round(32'h40, 1);
        check("t2_e16_r1", {30'd0, u_bim.r_table[16]}, 32'd2);
        check("t2_mis_r1", mcnt_b, 32'd1);
        round(32'h40, 1);
        check("t2_e16_r2", {30'd0, u_bim.r_table[16]}, 32'd3);
        round(32'h40, 1);
        check("t2_e16_r3", {30'd0, u_bim.r_table[16]}, 32'd3);
        check("t2_mis_r3", mcnt_b, 32'd1);
        check("t2_br_r3",  bcnt_b, 32'd3);
        current_pc = 32'h40;
        #1;
        check("t2_taken", {31'd0, taken_b}, 32'd1);

        // Saturate bimodal entry 19, then reset mid-RUN
        round(32'h4C, 1);
        round(32'h4C, 1);
        check("t6_e19_pre", {30'd0, u_bim.r_table[19]}, 32'd3);
        reset_and_init();
        check("t6_e19_post", {30'd0, u_bim.r_table[19]}, 32'd1);
        check("t6_br",   bcnt_b, 32'd0);
        check("t6_mis",  mcnt_b, 32'd0);
        check("t6_hist", {27'd0, u_gsh.r_history}, 32'd0);

        // gshare: two taken build history 00011, then PC 0x40 hits entry 19
        round(32'h40, 1);
        round(32'h40, 1);
        check("t3_hist_pre", {27'd0, u_gsh.r_history}, 32'h03);
        check("t3_e17", {30'd0, u_gsh.r_table[17]}, 32'd2);
        round(32'h40, 0);
        check("t3_e19",  {30'd0, u_gsh.r_table[19]}, 32'd0);
        check("t3_hist", {27'd0, u_gsh.r_history}, 32'h06);

        // Stall with update held: last stage trained three times
        cyc(0, 32'h40, 0, 0, 0, 0);
        cyc(0, FILL,   0, 0, 0, 0);
        repeat (3) cyc(0, FILL, 1, 0, 1, 0);
        cyc(0, FILL, 0, 0, 0, 0);
        check("t4_br_b", bcnt_b, 32'd6);
        check("t4_br_g", bcnt_g, 32'd6);
        check("t4_e16_b", {30'd0, u_bim.r_table[16]}, 32'd0);
        check("t4_e22_g", {30'd0, u_gsh.r_table[22]}, 32'd0);

        // Flush then update: resolve is dropped
        cyc(0, FILL, 0, 1, 0, 0);
        cyc(0, FILL, 0, 0, 1, 1);
        check("t5_br_b", bcnt_b, 32'd6);
        check("t5_e16_b", {30'd0, u_bim.r_table[16]}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            cyc(0, {$urandom_range(0, 63), 2'b00}, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
